// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback-side bundle for the regfile_mp register file.
// The master drives the read/write/mark requests. The slave (the register file)
// returns the registered read data, the busy flags and init_done.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            rd_en;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            init_done;
  logic            mark_en;
  logic [AW-1:0]   mark_addr;
  logic            rs1_busy;
  logic            rs2_busy;

  modport master (
    output rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
    input  rs1_data, rs2_data, init_done, rs1_busy, rs2_busy
  );

  modport slave (
    input  rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, mark_en, mark_addr,
    output rs1_data, rs2_data, init_done, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2-read/1-write integer register file for the decode stage.
// - Registered reads under rd_en, so a low rd_en stalls the outputs.
// - Same-cycle write-to-read bypass.
// - Optional hardwired-zero x0.
// - A post-reset sequencer clears the array one entry per cycle and then raises init_done.
// - The array itself has no reset, so it can map onto RAM.
// Optional feature: define REGFILE_SCOREBOARD_EN to keep a per-register busy bit.
// mark_en sets the bit and an accepted write clears it. Without the macro,
// rs1_busy/rs2_busy read as 0 and the mark inputs are ignored.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state;
  logic [AW-1:0]   clr_idx;
  logic [XLEN-1:0] mem [NREGS];
  logic            wr_ok;
  logic [XLEN-1:0] rs1_nxt;
  logic [XLEN-1:0] rs2_nxt;
  logic            rs1_busy_nxt;
  logic            rs2_busy_nxt;

  // True for an address that names real, writable storage.
  // This excludes out-of-range addresses and the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok = bus.wr_en && (state == READY) && addr_live(bus.wr_addr);

  // Next read values.
  // Dead addresses and the CLEAR phase read as zero. Otherwise a same-cycle
  // accepted write to the same address bypasses the array.
  always_comb begin
    rs1_nxt = '0;
    rs2_nxt = '0;
    if (addr_live(bus.rs1_addr) && (state == READY)) begin
      if (wr_ok && (bus.wr_addr == bus.rs1_addr)) rs1_nxt = bus.wr_data;
      else                                        rs1_nxt = mem[bus.rs1_addr];
    end
    if (addr_live(bus.rs2_addr) && (state == READY)) begin
      if (wr_ok && (bus.wr_addr == bus.rs2_addr)) rs2_nxt = bus.wr_data;
      else                                        rs2_nxt = mem[bus.rs2_addr];
    end
  end

  // Storage array without a reset.
  // The clear sequencer owns the write port during CLEAR; writeback owns it afterwards.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_idx] <= '0;
    else if (wr_ok)     mem[bus.wr_addr] <= bus.wr_data;
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] busy;
  logic             mark_ok;

  assign mark_ok = bus.mark_en && addr_live(bus.mark_addr);

  // Busy bits.
  // Everything is cleared while the array clears. A new producer's mark is
  // applied after a same-cycle write clear, so the mark wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (state == CLEAR) begin
      busy <= '0;
    end else begin
      if (wr_ok)   busy[bus.wr_addr]   <= 1'b0;
      if (mark_ok) busy[bus.mark_addr] <= 1'b1;
    end
  end

  // Busy as seen by a reader: after a same-cycle write clear, before a same-cycle mark.
  always_comb begin
    rs1_busy_nxt = 1'b0;
    rs2_busy_nxt = 1'b0;
    if (addr_live(bus.rs1_addr) && (state == READY) &&
        !(wr_ok && (bus.wr_addr == bus.rs1_addr)))
      rs1_busy_nxt = busy[bus.rs1_addr];
    if (addr_live(bus.rs2_addr) && (state == READY) &&
        !(wr_ok && (bus.wr_addr == bus.rs2_addr)))
      rs2_busy_nxt = busy[bus.rs2_addr];
  end
`else
  logic unused_mark;

  assign unused_mark  = ^{bus.mark_en, bus.mark_addr};
  assign rs1_busy_nxt = 1'b0;
  assign rs2_busy_nxt = 1'b0;
`endif

  // Clear sequencer FSM and registered read outputs.
  // init_done rises on the edge that clears the last entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= CLEAR;
      clr_idx       <= '0;
      bus.init_done <= 1'b0;
      bus.rs1_data  <= '0;
      bus.rs2_data  <= '0;
      bus.rs1_busy  <= 1'b0;
      bus.rs2_busy  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state         <= READY;
            bus.init_done <= 1'b1;
          end
        end
        READY:   state <= READY;
        default: state <= CLEAR;
      endcase
      if (bus.rd_en) begin
        bus.rs1_data <= rs1_nxt;
        bus.rs2_data <= rs2_nxt;
        bus.rs1_busy <= rs1_busy_nxt;
        bus.rs2_busy <= rs2_busy_nxt;
      end
    end
  end

`ifndef SYNTHESIS
  // Trace of every write the array actually accepts.
  always @(posedge clk) begin
    if (!rst && wr_ok) $display("%m: write x%0d <= 0x%h", bus.wr_addr, bus.wr_data);
  end
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: self-checking bench for regfile_mp.
// Two instances share all inputs: NREGS=32 and NREGS=20 (same 5-bit address width).
// The reference model is a plain array per instance, gated by a count of edges since reset.
module tb_regfile_mp;
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en;
  logic [4:0]  rs1_addr, rs2_addr, wr_addr, mark_addr;
  logic        wr_en, mark_en;
  logic [31:0] wr_data;

  regfile_mp_if #(.XLEN(32), .NREGS(32)) bus32 ();
  regfile_mp_if #(.XLEN(32), .NREGS(20)) bus20 ();

  regfile_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  regfile_mp #(.XLEN(32), .NREGS(20), .ZERO_REG(1)) dut20 (.clk(clk), .rst(rst), .bus(bus20));

  assign bus32.rd_en = rd_en;     assign bus20.rd_en = rd_en;
  assign bus32.rs1_addr = rs1_addr;  assign bus20.rs1_addr = rs1_addr;
  assign bus32.rs2_addr = rs2_addr;  assign bus20.rs2_addr = rs2_addr;
  assign bus32.wr_en = wr_en;     assign bus20.wr_en = wr_en;
  assign bus32.wr_addr = wr_addr;   assign bus20.wr_addr = wr_addr;
  assign bus32.wr_data = wr_data;   assign bus20.wr_data = wr_data;
  assign bus32.mark_en = mark_en;   assign bus20.mark_en = mark_en;
  assign bus32.mark_addr = mark_addr; assign bus20.mark_addr = mark_addr;

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          nregsOf [2] = '{32, 20};
  int          cyc;
  logic [31:0] mMem [2][32];
  bit          mBusy [2][32];
  logic [31:0] expD1 [2], expD2 [2];
  bit          expB1 [2], expB2 [2], expInit [2];

  function automatic logic [31:0] mRead(input int k, input logic [4:0] a);
    int ai = int'(a);
    if (ai == 0 || ai >= nregsOf[k] || cyc < nregsOf[k]) return 32'h0;
    if (wr_en && int'(wr_addr) == ai) return wr_data;
    return mMem[k][ai];
  endfunction

  function automatic bit mBusyRd(input int k, input logic [4:0] a);
    int ai = int'(a);
    if (!SB || ai == 0 || ai >= nregsOf[k] || cyc < nregsOf[k]) return 1'b0;
    if (wr_en && int'(wr_addr) == ai) return 1'b0;
    return mBusy[k][ai];
  endfunction

  function automatic void modelEdge();
    for (int k = 0; k < 2; k++) begin
      if (rd_en) begin
        expD1[k] = mRead(k, rs1_addr);
        expD2[k] = mRead(k, rs2_addr);
        expB1[k] = mBusyRd(k, rs1_addr);
        expB2[k] = mBusyRd(k, rs2_addr);
      end
      if (cyc >= nregsOf[k]) begin
        if (wr_en && wr_addr != 0 && int'(wr_addr) < nregsOf[k]) begin
          mMem[k][wr_addr]  = wr_data;
          mBusy[k][wr_addr] = 1'b0;
        end
        if (mark_en && mark_addr != 0 && int'(mark_addr) < nregsOf[k])
          mBusy[k][mark_addr] = 1'b1;
      end
    end
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (cyc == nregsOf[k])
        for (int i = 0; i < 32; i++) begin
          mMem[k][i]  = 32'h0;
          mBusy[k][i] = 1'b0;
        end
      expInit[k] = (cyc >= nregsOf[k]);
    end
  endfunction

  function automatic void modelReset();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      expD1[k] = 32'h0; expD2[k] = 32'h0;
      expB1[k] = 1'b0;  expB2[k] = 1'b0; expInit[k] = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("d32 rs1_data", bus32.rs1_data, expD1[0]);
    checkOutput("d32 rs2_data", bus32.rs2_data, expD2[0]);
    checkOutput("d32 rs1_busy", 32'(bus32.rs1_busy), 32'(expB1[0]));
    checkOutput("d32 rs2_busy", 32'(bus32.rs2_busy), 32'(expB2[0]));
    checkOutput("d32 init_done", 32'(bus32.init_done), 32'(expInit[0]));
    checkOutput("d20 rs1_data", bus20.rs1_data, expD1[1]);
    checkOutput("d20 rs2_data", bus20.rs2_data, expD2[1]);
    checkOutput("d20 rs1_busy", 32'(bus20.rs1_busy), 32'(expB1[1]));
    checkOutput("d20 rs2_busy", 32'(bus20.rs2_busy), 32'(expB2[1]));
    checkOutput("d20 init_done", 32'(bus20.init_done), 32'(expInit[1]));
  endtask

  // Called at a falling edge: drive inputs, clock once, check #1 after the rising edge.
  task automatic applyStimulus(input bit re, input logic [4:0] a1, input logic [4:0] a2,
                               input bit we, input logic [4:0] wa, input logic [31:0] wd,
                               input bit me, input logic [4:0] ma);
    rd_en = re; rs1_addr = a1; rs2_addr = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    mark_en = me; mark_addr = ma;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
    @(negedge clk);
  endtask

  // Called at a falling edge: assert reset, check the asynchronous clear, release at the next falling edge.
  task automatic doReset();
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    checkOutput("async rst rs1_data", bus32.rs1_data, 32'h0);
    @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [4:0] ra();
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 1'b1; rd_en = 0; rs1_addr = 0; rs2_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; mark_en = 0; mark_addr = 0;
    modelReset();
    @(negedge clk);
    doReset();

    // Clear phase: random reads and writes; init_done must rise after exactly 32 edges.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, ra(), ra(), 1'($urandom_range(0, 1)), ra(), $urandom(), 1'b0, 5'd0);
      checkOutput("d32 init count", 32'(bus32.init_done), 32'(i == 31));
      checkOutput("d32 clear read", bus32.rs1_data, 32'h0);
    end

    // Write then read x5 on both ports.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x5 rs1", bus32.rs1_data, 32'hDEADBEEF);
    checkOutput("x5 rs2", bus32.rs2_data, 32'hDEADBEEF);
    checkOutput("x5 rs1 n20", bus20.rs1_data, 32'hDEADBEEF);

    // x0 is hardwired to zero.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x0 reads zero", bus32.rs1_data, 32'h0);

    // Same-cycle bypass, then a stall while x7 is overwritten.
    applyStimulus(1'b1, 5'd0, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
    checkOutput("bypass rs2", bus32.rs2_data, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd7, 1'b1, 5'd7, 32'h1, 1'b0, 5'd0);
      checkOutput("stall hold rs2", bus32.rs2_data, 32'hA5A5A5A5);
    end
    applyStimulus(1'b1, 5'd0, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x7 after stall", bus32.rs2_data, 32'h1);

    // Out-of-range addresses on the 20-entry instance.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd25, 32'hCAFEF00D, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd25, 5'd25, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("n20 addr25", bus20.rs1_data, 32'h0);
    checkOutput("n32 addr25", bus32.rs1_data, 32'hCAFEF00D);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd19, 32'h13579BDF, 1'b0, 5'd0);
    applyStimulus(1'b1, 5'd19, 5'd25, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("n20 addr19", bus20.rs1_data, 32'h13579BDF);
    checkOutput("n20 addr25 rs2", bus20.rs2_data, 32'h0);

    // Scoreboard: mark, then write clears, then mark+write leaves the bit set.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x9 marked busy", 32'(bus32.rs1_busy), 32'(SB));
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 5'd9, 32'h42, 1'b0, 5'd0);
    checkOutput("x9 write data", bus32.rs1_data, 32'h42);
    checkOutput("x9 write busy", 32'(bus32.rs1_busy), 32'h0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h77, 1'b1, 5'd9);
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x9 mark wins", 32'(bus32.rs1_busy), 32'(SB));
    checkOutput("x9 mark data", bus32.rs1_data, 32'h77);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), ra(), ra(), 1'($urandom_range(0, 1)), ra(),
                    $urandom(), 1'($urandom_range(0, 3) == 0), ra());

    // Reset in the middle of the clear phase, with writes to x3 during the clear.
    doReset();
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 5'd3, ra(), 1'b1, 5'd3, 32'hFF, 1'b1, 5'd3);
    doReset();
    checkOutput("re-reset init", 32'(bus32.init_done), 32'h0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 5'd3, 5'd5, 1'b1, 5'd3, 32'hFF, 1'b0, 5'd0);
      checkOutput("d32 init count 2", 32'(bus32.init_done), 32'(i == 31));
    end
    applyStimulus(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkOutput("x3 cleared", bus32.rs1_data, 32'h0);
    checkOutput("x5 cleared", bus32.rs2_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Generalises data width and register count, and hardwires register 0 to zero.
- Adds write-to-read bypass, a read enable for pipeline stalls, and an automatic post-reset clear sequencer that signals when the array is usable.
- Sits in the decode stage: read addresses come from the instruction, the write port comes from writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (2..64; need not be a power of 2).
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes.
- AW (localparam), $clog2(NREGS), address width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  capture new read results this cycle; low holds outputs (stall).
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rs1_data  output  XLEN  registered read data, port 1.
- rs2_data  output  XLEN  registered read data, port 2.
- wr_en  input  1  write enable.
- wr_addr  input  AW  write address.
- wr_data  input  XLEN  write data.
- init_done  output  1  high once the post-reset clear has completed.
- mark_en  input  1  mark wr-destination busy (scoreboard; see Optional Feature).
- mark_addr  input  AW  register to mark busy.
- rs1_busy  output  1  busy flag of the register read on port 1, registered with rs1_data.
- rs2_busy  output  1  busy flag of the register read on port 2, registered with rs2_data.

Behaviour:
- Reset, asynchronous: rs1_data=0, rs2_data=0, rs1_busy=0, rs2_busy=0, init_done=0, state=CLEAR, clear index=0.
- The storage array is NOT reset asynchronously, so it can map to RAM.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle writes 0 to array[index]; index increments.
  - After index reaches NREGS-1, go to READY next cycle, so init_done rises exactly NREGS cycles after rst deasserts.
  - External writes are ignored while in CLEAR.
  - Reads with rd_en return 0.
- Reset asserted mid-CLEAR restarts CLEAR from index 0.
- READY:
  - Stays in READY until reset.
  - Write: on a clock edge with wr_en=1, array[wr_addr] <= wr_data.
  - Writes are ignored if wr_addr >= NREGS, or if ZERO_REG=1 and wr_addr=0.
- Read latency is 1 cycle. At edge N with rd_en=1, rsX_data takes the value for rsX_addr sampled at N; the value is visible after edge N.
- rd_en=0: outputs hold their previous value.
- Read value priority, highest first:
  - 0 if ZERO_REG=1 and addr=0.
  - 0 if addr >= NREGS.
  - wr_data if wr_en=1, state=READY and wr_addr==addr (bypass: same-cycle write is seen).
  - Otherwise array[addr].
- Both ports may read the same address, and both see the bypass.
- Simulation-only: a $display of each accepted write (address, data) is kept under `ifndef SYNTHESIS`.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- Defined: a busy bit is kept per register.
  - mark_en sets busy[mark_addr].
  - An accepted write clears busy[wr_addr].
  - Simultaneous mark and write to the same addr: busy ends set (the new producer wins).
  - Register 0 (ZERO_REG=1) and out-of-range addresses are never busy.
  - All busy bits clear during CLEAR.
  - rsX_busy is registered under rd_en with the same timing as rsX_data. It reflects the bit after a same-cycle clear, but before a same-cycle set.
- Not defined: no busy storage; rs1_busy/rs2_busy are tied 0; mark_en and mark_addr are ignored.
- Ports exist in both builds.

Test Plan:
- Reset then idle, NREGS=32 -> init_done low for 32 cycles after rst falls, high on the 33rd; reads of every addr with rd_en return 0.
- After init, write x5=0xDEADBEEF, next cycle read rs1=5, rs2=5 -> both 0xDEADBEEF one cycle later; write x0=0x1234 then read 0 -> 0.
- Same-cycle bypass: wr_en, wr_addr=7, wr_data=0xA5A5A5A5 with rs2_addr=7, rd_en=1 -> rs2_data=0xA5A5A5A5 after that edge; stall rd_en=0 for 3 cycles while writing x7=0x1 -> rs2_data holds 0xA5A5A5A5.
- Reset pulse at clear index 10 -> outputs 0 immediately; init_done rises 32 cycles after the second deassert; wr_en during CLEAR with x3=0xFF -> x3 reads 0 afterwards.
- NREGS=20: write addr 25 -> ignored; read addr 25 -> 0; addr 19 writes/reads normally.
- REGFILE_SCOREBOARD_EN: mark x9, read -> rs1_busy=1; write x9=0x42 with rd_en, rs1_addr=9 same cycle -> rs1_data=0x42, rs1_busy=0; mark and write x9 together, then read -> rs1_busy=1. Without the macro -> busy is always 0.
